// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register file behind an auto-incrementing pointer.
// Fabric sees a one-cycle write strobe per register write and a combinational read port.
//
// state     | meaning
// S_IDLE    | bus idle or not addressed, wait for START
// S_ADDR    | shifting in 7-bit address + R/W
// S_ADDR_ACK| driving address ACK
// S_WR_BYTE | shifting in pointer or data byte
// S_WR_ACK  | driving data ACK
// S_RD_BYTE | shifting out read data
// S_RD_ACK  | SDA released, sampling master ACK/NACK
// S_WAIT_STOP| transaction finished or rejected, wait for START/STOP
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         REG_AW      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_pad_i,
  input  logic              sda_pad_i,
  output logic              sda_pad_o,
  output logic              sda_padoen_o,
  output logic              wr_valid_o,
  output logic [REG_AW-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  input  logic [REG_AW-1:0] rd_addr_i,
  output logic [7:0]        rd_data_o,
  output logic              busy_o
);

  localparam int NREG = 1 << REG_AW;
  localparam logic [REG_AW-1:0] PTR_ONE = {{(REG_AW-1){1'b0}}, 1'b1};

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ADDR_ACK  = 3'd2;
  localparam logic [2:0] S_WR_BYTE   = 3'd3;
  localparam logic [2:0] S_WR_ACK    = 3'd4;
  localparam logic [2:0] S_RD_BYTE   = 3'd5;
  localparam logic [2:0] S_RD_ACK    = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  logic [7:0]        regs [NREG];
  logic [2:0]        scl_sr, sda_sr;
  logic              ev_scl_rise, ev_scl_fall, ev_start, ev_stop, sda_smp;
  logic [2:0]        state;
  logic [3:0]        bit_cnt;
  logic [7:0]        shift, tx;
  logic [7:0]        rx_byte;
  logic [REG_AW-1:0] ptr;
  logic              rw, first_byte;

  assign sda_pad_o = 1'b0;
  assign rd_data_o = regs[rd_addr_i];
  assign rx_byte   = {shift[6:0], sda_smp};

  // [1:0] synchronize, [2] is the previous value for edge detection; events are registered
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sr      <= 3'b111;
      sda_sr      <= 3'b111;
      ev_scl_rise <= 1'b0;
      ev_scl_fall <= 1'b0;
      ev_start    <= 1'b0;
      ev_stop     <= 1'b0;
      sda_smp     <= 1'b1;
    end else begin
      scl_sr      <= {scl_sr[1:0], scl_pad_i};
      sda_sr      <= {sda_sr[1:0], sda_pad_i};
      ev_scl_rise <= scl_sr[1] & ~scl_sr[2];
      ev_scl_fall <= ~scl_sr[1] & scl_sr[2];
      ev_start    <= scl_sr[1] & scl_sr[2] & ~sda_sr[1] & sda_sr[2];
      ev_stop     <= scl_sr[1] & scl_sr[2] & sda_sr[1] & ~sda_sr[2];
      sda_smp     <= sda_sr[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      bit_cnt      <= 4'd0;
      shift        <= 8'd0;
      tx           <= 8'd0;
      ptr          <= '0;
      rw           <= 1'b0;
      first_byte   <= 1'b0;
      sda_padoen_o <= 1'b0;
      busy_o       <= 1'b0;
      wr_valid_o   <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= 8'd0;
      for (int i = 0; i < NREG; i++) regs[i] <= 8'd0;
    end else begin
      wr_valid_o <= 1'b0;
      if (ev_start) begin
        state        <= S_ADDR;
        bit_cnt      <= 4'd0;
        sda_padoen_o <= 1'b0;
        busy_o       <= 1'b0;
      end else if (ev_stop) begin
        state        <= S_IDLE;
        sda_padoen_o <= 1'b0;
        busy_o       <= 1'b0;
      end else begin
        case (state)
          S_ADDR: begin
            if (ev_scl_rise && bit_cnt != 4'd8) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (ev_scl_fall && bit_cnt == 4'd8) begin
              if (shift[7:1] == TARGET_ADDR) begin
                sda_padoen_o <= 1'b1;
                busy_o       <= 1'b1;
                rw           <= shift[0];
                state        <= S_ADDR_ACK;
              end else begin
                state <= S_WAIT_STOP;
              end
            end
          end
          S_ADDR_ACK: begin
            if (ev_scl_fall) begin
              if (rw) begin
                tx           <= regs[ptr];
                ptr          <= ptr + PTR_ONE;
                sda_padoen_o <= ~regs[ptr][7];
                bit_cnt      <= 4'd1;
                state        <= S_RD_BYTE;
              end else begin
                sda_padoen_o <= 1'b0;
                bit_cnt      <= 4'd0;
                first_byte   <= 1'b1;
                state        <= S_WR_BYTE;
              end
            end
          end
          S_WR_BYTE: begin
            if (ev_scl_rise && bit_cnt != 4'd8) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (first_byte) begin
                  ptr        <= rx_byte[REG_AW-1:0];
                  first_byte <= 1'b0;
                end else begin
                  regs[ptr]  <= rx_byte;
                  wr_valid_o <= 1'b1;
                  wr_addr_o  <= ptr;
                  wr_data_o  <= rx_byte;
                  ptr        <= ptr + PTR_ONE;
                end
              end
            end else if (ev_scl_fall && bit_cnt == 4'd8) begin
              sda_padoen_o <= 1'b1;
              state        <= S_WR_ACK;
            end
          end
          S_WR_ACK: begin
            if (ev_scl_fall) begin
              sda_padoen_o <= 1'b0;
              bit_cnt      <= 4'd0;
              state        <= S_WR_BYTE;
            end
          end
          S_RD_BYTE: begin
            // tx[7] is the bit currently on the bus
            if (ev_scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_padoen_o <= 1'b0;
                bit_cnt      <= 4'd0;
                state        <= S_RD_ACK;
              end else begin
                sda_padoen_o <= ~tx[6];
                tx           <= {tx[6:0], 1'b0};
                bit_cnt      <= bit_cnt + 4'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (ev_scl_rise) begin
              if (!sda_smp) begin
                tx      <= regs[ptr];
                ptr     <= ptr + PTR_ONE;
                bit_cnt <= 4'd1;
              end else begin
                busy_o <= 1'b0;
                state  <= S_WAIT_STOP;
              end
            end else if (ev_scl_fall && bit_cnt == 4'd1) begin
              sda_padoen_o <= ~tx[7];
              state        <= S_RD_BYTE;
            end
          end
          S_WAIT_STOP: begin
            sda_padoen_o <= 1'b0;
            busy_o       <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bus-level bench for i2c_target_regs: a bit-banged I2C master, a register/pointer
// reference model, and scoreboard monitors for write strobes and read bytes.
module tb_i2c_target_regs;

  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_pad_o, sda_padoen_o, wr_valid_o, busy_o;
  logic [3:0] wr_addr_o;
  logic [3:0] rd_addr_i = 4'd0;
  logic [7:0] wr_data_o, rd_data_o;

  int          model_regs [16];
  int          model_ptr;
  logic [11:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic [7:0]  wbuf [8];
  int          errors = 0, checks = 0;
  logic        rd_seen = 1'b0;
  logic [7:0]  rd_act;
  logic        watch_nodrive = 1'b0;
  int          drive_seen = 0;

  assign sda_bus = sda_m & ~(sda_padoen_o & ~sda_pad_o);

  i2c_target_regs #(.TARGET_ADDR(7'h42), .REG_AW(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .scl_pad_i    (scl_m),
    .sda_pad_i    (sda_bus),
    .sda_pad_o    (sda_pad_o),
    .sda_padoen_o (sda_padoen_o),
    .wr_valid_o   (wr_valid_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got no end of test, required finish within 90000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // write-strobe scoreboard
  always @(negedge clk) begin
    logic [11:0] e;
    if (!rst && wr_valid_o) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr=%0d data=%02h, required no write", wr_addr_o, wr_data_o);
      end else begin
        e = exp_wr.pop_front();
        if ({wr_addr_o, wr_data_o} !== e) begin
          errors++;
          $display("FAIL wr_strobe: got addr=%0d data=%02h, required addr=%0d data=%02h",
                   wr_addr_o, wr_data_o, e[11:8], e[7:0]);
        end
      end
    end
  end

  // read-byte scoreboard
  always @(posedge clk) begin
    logic [7:0] e;
    if (rd_seen) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %02h, required no read", rd_act);
      end else begin
        e = exp_rd.pop_front();
        if (rd_act !== e) begin
          errors++;
          $display("FAIL rd_byte: got %02h, required %02h", rd_act, e);
        end
      end
    end
  end

  always @(negedge clk) if (watch_nodrive && sda_padoen_o) drive_seen++;

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; wq();
      scl_m = 1'b1; wq(); wq();
      scl_m = 1'b0; wq();
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    ack = sda_bus; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wq();
      scl_m = 1'b1; wq();
      b[i] = sda_bus; wq();
      scl_m = 1'b0; wq();
    end
    sda_m = nack; wq();
    scl_m = 1'b1; wq(); wq();
    scl_m = 1'b0; wq();
    sda_m = 1'b1;
  endtask

  // addr byte, then wbuf[0] (pointer), then wbuf[1..n-1] (data)
  task automatic do_write(input logic [6:0] a, input int n);
    logic ack;
    logic hit;
    hit = (a == 7'h42);
    i2c_start();
    write_byte({a, 1'b0}, ack);
    check("addr_ack", ack, hit ? 0 : 1);
    if (hit) check("busy_on", busy_o, 1);
    for (int k = 0; k < n; k++) begin
      if (hit) begin
        if (k == 0) model_ptr = int'(wbuf[0]) % 16;
        else begin
          exp_wr.push_back({4'(model_ptr), wbuf[k]});
          model_regs[model_ptr] = int'(wbuf[k]);
          model_ptr = (model_ptr + 1) % 16;
        end
      end
      write_byte(wbuf[k], ack);
      check("data_ack", ack, hit ? 0 : 1);
    end
    i2c_stop();
    wq();
    check("busy_off", busy_o, 0);
  endtask

  task automatic do_read(input int n, input logic set_ptr, input logic [3:0] p);
    logic ack;
    logic [7:0] b;
    i2c_start();
    if (set_ptr) begin
      write_byte(8'h84, ack);
      check("rd_wr_addr_ack", ack, 0);
      write_byte({4'h0, p}, ack);
      check("rd_ptr_ack", ack, 0);
      model_ptr = int'(p);
      i2c_start();
    end
    write_byte(8'h85, ack);
    check("rd_addr_ack", ack, 0);
    check("rd_busy_on", busy_o, 1);
    for (int k = 0; k < n; k++) begin
      exp_rd.push_back(8'(model_regs[model_ptr]));
      model_ptr = (model_ptr + 1) % 16;
      read_byte(k == n - 1, b);
      rd_act = b;
      rd_seen = 1'b1;
      @(negedge clk);
      rd_seen = 1'b0;
    end
    check("nack_release", sda_padoen_o, 0);
    check("nack_busy", busy_o, 0);
    i2c_stop();
    wq();
  endtask

  task automatic compare_regs();
    for (int a = 0; a < 16; a++) begin
      rd_addr_i = 4'(a);
      @(negedge clk);
      check($sformatf("rd_data[%0d]", a), rd_data_o, 32'(model_regs[a]));
    end
  endtask

  initial begin
    logic ack;
    int kind, n;
    logic [6:0] a;
    for (int i = 0; i < 16; i++) model_regs[i] = 0;
    model_ptr = 0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_padoen", sda_padoen_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_wr_valid", wr_valid_o, 0);
    check("rst_sda_o", sda_pad_o, 0);
    compare_regs();

    // two-register write from pointer 3
    wbuf[0] = 8'h03; wbuf[1] = 8'hA5; wbuf[2] = 8'h5A;
    do_write(7'h42, 3);
    check("wr_pulses_done", exp_wr.size(), 0);
    rd_addr_i = 4'd3; @(negedge clk); check("reg3", rd_data_o, 8'hA5);
    rd_addr_i = 4'd4; @(negedge clk); check("reg4", rd_data_o, 8'h5A);
    compare_regs();

    // pointer wrap on write then on read
    wbuf[0] = 8'h0F; wbuf[1] = 8'h11; wbuf[2] = 8'h22;
    do_write(7'h42, 3);
    rd_addr_i = 4'd0; @(negedge clk); check("reg0_wrap", rd_data_o, 8'h22);
    do_read(2, 1'b1, 4'hF);
    compare_regs();

    // address mismatch: no drive, no write
    watch_nodrive = 1'b1;
    wbuf[0] = 8'h01; wbuf[1] = 8'hFF;
    do_write(7'h43, 2);
    watch_nodrive = 1'b0;
    check("mismatch_no_drive", drive_seen, 0);
    compare_regs();

    // STOP in the middle of a data byte
    wbuf[0] = 8'h02; wbuf[1] = 8'h77;
    do_write(7'h42, 2);
    i2c_start();
    write_byte(8'h84, ack); check("mid_addr_ack", ack, 0);
    write_byte(8'h02, ack); check("mid_ptr_ack", ack, 0);
    model_ptr = 2;
    send_bits(8'hC3, 4);
    i2c_stop();
    wq();
    check("mid_busy", busy_o, 0);
    compare_regs();
    do_read(1, 1'b0, 4'h0);

    // randomized traffic
    for (int it = 0; it < 16; it++) begin
      kind = int'($urandom_range(0, 3));
      n = int'($urandom_range(1, 4));
      if (kind <= 1) begin
        for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
        do_write(7'h42, n);
      end else if (kind == 2) begin
        do_read(int'($urandom_range(1, 3)), 1'($urandom), 4'($urandom));
      end else begin
        a = 7'($urandom);
        if (a == 7'h42) a = 7'h13;
        for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
        do_write(a, n);
      end
      compare_regs();
    end

    // reset while the target drives a 0 bit
    wbuf[0] = 8'h05; wbuf[1] = 8'h35;
    do_write(7'h42, 2);
    i2c_start();
    write_byte(8'h84, ack); check("rr_addr_ack", ack, 0);
    write_byte(8'h05, ack); check("rr_ptr_ack", ack, 0);
    i2c_start();
    write_byte(8'h85, ack); check("rr_rd_ack", ack, 0);
    check("rr_driving_zero", sda_padoen_o, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rr_release", sda_padoen_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model_regs[i] = 0;
    model_ptr = 0;
    scl_m = 1'b1; sda_m = 1'b1; wq();
    check("rr_busy", busy_o, 0);
    compare_regs();
    do_read(1, 1'b0, 4'h0);
    wbuf[0] = 8'h07; wbuf[1] = 8'h99; wbuf[2] = 8'h3C;
    do_write(7'h42, 3);
    compare_regs();

    repeat (4) @(negedge clk);
    check("wr_queue_empty", exp_wr.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
